// File: rtl/cv32e40p_fetch_queue_if.sv
// ----------------------------------------------------------------------------
// cv32e40p_fetch_queue_if
// Bundles the two handshakes of the instruction fetch queue:
//   - OBI instruction port: instr_req_o/instr_addr_o out, instr_gnt_i,
//     instr_rvalid_i, instr_rdata_i, instr_err_i in
//   - aligner side: fetch_valid_o/fetch_rdata_o/fetch_addr_o/fetch_err_o out,
//     fetch_ready_i in
// Modports:
//   master : the fetch queue itself (drives requests and the FIFO head)
//   slave  : the environment (memory responder plus aligner)
// ----------------------------------------------------------------------------
interface cv32e40p_fetch_queue_if;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        instr_err_i;
    logic        fetch_valid_o;
    logic        fetch_ready_i;
    logic [31:0] fetch_rdata_o;
    logic [31:0] fetch_addr_o;
    logic        fetch_err_o;

    modport master (
        output instr_req_o, instr_addr_o,
        input  instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_err_i,
        output fetch_valid_o, fetch_rdata_o, fetch_addr_o, fetch_err_o,
        input  fetch_ready_i
    );

    modport slave (
        input  instr_req_o, instr_addr_o,
        output instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_err_i,
        input  fetch_valid_o, fetch_rdata_o, fetch_addr_o, fetch_err_o,
        output fetch_ready_i
    );
endinterface

// File: rtl/cv32e40p_fetch_queue.sv
// ----------------------------------------------------------------------------
// cv32e40p_fetch_queue
// IF-stage prefetch queue. Issues word fetches on the OBI instruction port
// (up to MAX_OUTSTANDING in flight), buffers responses in a DEPTH-entry FIFO
// and hands them to the aligner with valid/ready. A branch flushes the FIFO
// and arranges for responses of already-issued fetches to be discarded.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   req_i          : fetch enable
//   branch_i       : redirect, branch_addr_i is the new target
//   bus            : OBI request/response and aligner handshake (master)
//   busy_o         : request pending or transactions still in flight
//   occupancy_o    : number of FIFO entries
// Optional feature macro: CV32E40P_FETCH_ERR_EN (per-entry bus error and
// fetch halt after an errored response until the next branch).
// Protocol check macro: CV32E40P_ASSERT_ON.
// ----------------------------------------------------------------------------
`ifdef CV32E40P_ASSERT_ON
module cv32e40p_fetch_queue_chk #(
    parameter int unsigned OUT_W = 2
) (
    input logic             clk,
    input logic             rst_n,
    input logic             rvalid,
    input logic [OUT_W-1:0] outstanding
);
    // A response may only arrive for a granted transaction
    a_no_spurious_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
        !(rvalid && (outstanding == {OUT_W{1'b0}})));
endmodule
`endif

module cv32e40p_fetch_queue #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_i,
    input  logic                         branch_i,
    input  logic [31:0]                  branch_addr_i,
    cv32e40p_fetch_queue_if.master       bus,
    output logic                         busy_o,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [OUT_W-1:0] MAX_L   = OUT_W'(MAX_OUTSTANDING);
    localparam logic [SUM_W-1:0] DEPTH_L = SUM_W'(DEPTH);

    typedef enum logic [0:0] {IDLE = 1'b0, REQ = 1'b1} state_e;

    state_e            r_state, w_state_nxt;
    logic [31:0]       r_next_addr, w_next_addr_nxt, r_req_addr, r_resp_addr;
    logic [OUT_W-1:0]  r_outstanding, w_outstanding_nxt, r_discard, w_discard_nxt;
    logic [CNT_W-1:0]  r_count, w_count_nxt;
    logic [PTR_W-1:0]  r_rd_ptr, r_wr_ptr;
    logic              r_armed, r_stale, w_halt_nxt;
    logic [31:0]       r_mem_data [DEPTH];
    logic [31:0]       r_mem_addr [DEPTH];
    logic [31:0]       w_branch_target;
    logic              w_gnt, w_push, w_pop, w_stale_gnt, w_discard_dec;
    logic              w_credit, w_fetch_valid;
`ifdef CV32E40P_FETCH_ERR_EN
    logic              r_halt;
    logic              r_mem_err [DEPTH];
`endif

    assign w_branch_target = branch_addr_i & 32'hFFFF_FFFC;
    assign w_fetch_valid   = (r_count != {CNT_W{1'b0}});
    assign w_gnt           = (r_state == REQ) && bus.instr_gnt_i;
    assign w_pop           = w_fetch_valid && bus.fetch_ready_i && !branch_i;
    // The branch cycle drops any response; otherwise stale responses are eaten first
    assign w_push          = bus.instr_rvalid_i && !branch_i && (r_discard == {OUT_W{1'b0}});
    assign w_discard_dec   = bus.instr_rvalid_i && (r_discard != {OUT_W{1'b0}});
    // Grant of a request that was already on the bus when a branch arrived
    assign w_stale_gnt     = w_gnt && r_stale && !branch_i;

    // Next values of counters, fill level, fetch address and halt flag
    always_comb begin
        w_outstanding_nxt = r_outstanding;
        case ({w_gnt, bus.instr_rvalid_i})
            2'b10:   w_outstanding_nxt = r_outstanding + OUT_W'(1'b1);
            2'b01:   w_outstanding_nxt = r_outstanding - OUT_W'(1'b1);
            default: w_outstanding_nxt = r_outstanding;
        endcase

        w_discard_nxt = r_discard;
        if (branch_i) begin
            // everything granted up to and including this cycle, minus a response now
            w_discard_nxt = w_outstanding_nxt;
        end else if (w_stale_gnt && !w_discard_dec) begin
            w_discard_nxt = r_discard + OUT_W'(1'b1);
        end else if (!w_stale_gnt && w_discard_dec) begin
            w_discard_nxt = r_discard - OUT_W'(1'b1);
        end else begin
            w_discard_nxt = r_discard;
        end

        w_count_nxt = r_count;
        if (branch_i) begin
            w_count_nxt = {CNT_W{1'b0}};
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + CNT_W'(1'b1);
                2'b01:   w_count_nxt = r_count - CNT_W'(1'b1);
                default: w_count_nxt = r_count;
            endcase
        end

        w_next_addr_nxt = r_next_addr;
        if (branch_i) begin
            w_next_addr_nxt = w_branch_target;
        end else if (w_gnt && !r_stale) begin
            w_next_addr_nxt = r_next_addr + 32'd4;
        end else begin
            w_next_addr_nxt = r_next_addr;
        end

`ifdef CV32E40P_FETCH_ERR_EN
        w_halt_nxt = r_halt;
        if (branch_i) begin
            w_halt_nxt = 1'b0;
        end else if (w_push && bus.instr_err_i) begin
            w_halt_nxt = 1'b1;
        end else begin
            w_halt_nxt = r_halt;
        end
`else
        w_halt_nxt = 1'b0;
`endif

        // Credit is judged on next-cycle values: a request in the next cycle
        // can never exceed the in-flight limit or overflow the FIFO.
        w_credit = r_armed && req_i && !branch_i && !w_halt_nxt &&
                   (w_outstanding_nxt < MAX_L) &&
                   (({{(SUM_W-OUT_W){1'b0}}, w_outstanding_nxt} +
                     {1'b0, w_count_nxt}) < DEPTH_L);
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_credit) begin
                    w_state_nxt = REQ;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            REQ: begin
                if (w_gnt) begin
                    w_state_nxt = (r_stale || !w_credit) ? IDLE : REQ;
                end else begin
                    w_state_nxt = REQ;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Control registers, pointers and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_next_addr   <= 32'h0000_0000;
            r_req_addr    <= 32'h0000_0000;
            r_resp_addr   <= 32'h0000_0000;
            r_outstanding <= {OUT_W{1'b0}};
            r_discard     <= {OUT_W{1'b0}};
            r_count       <= {CNT_W{1'b0}};
            r_rd_ptr      <= {PTR_W{1'b0}};
            r_wr_ptr      <= {PTR_W{1'b0}};
            r_armed       <= 1'b0;
            r_stale       <= 1'b0;
`ifdef CV32E40P_FETCH_ERR_EN
            r_halt        <= 1'b0;
`endif
        end else begin
            r_next_addr   <= w_next_addr_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_discard     <= w_discard_nxt;
            r_count       <= w_count_nxt;
`ifdef CV32E40P_FETCH_ERR_EN
            r_halt        <= w_halt_nxt;
`endif
            // OBI address must stay stable while a request waits for grant
            if ((r_state == REQ) && !bus.instr_gnt_i) begin
                r_req_addr <= r_req_addr;
            end else begin
                r_req_addr <= w_next_addr_nxt;
            end
            if (branch_i) begin
                r_armed     <= 1'b1;
                r_stale     <= (r_state == REQ) && !bus.instr_gnt_i;
                r_resp_addr <= w_branch_target;
                r_rd_ptr    <= {PTR_W{1'b0}};
                r_wr_ptr    <= {PTR_W{1'b0}};
            end else begin
                r_stale <= w_gnt ? 1'b0 : r_stale;
                if (w_push) begin
                    r_resp_addr <= r_resp_addr + 32'd4;
                    r_wr_ptr    <= r_wr_ptr + PTR_W'(1'b1);
                end else begin
                    r_resp_addr <= r_resp_addr;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1'b1);
                end else begin
                    r_rd_ptr <= r_rd_ptr;
                end
            end
        end
    end

    // FIFO storage; contents are only visible while the entry is valid
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= bus.instr_rdata_i;
            r_mem_addr[r_wr_ptr] <= r_resp_addr;
`ifdef CV32E40P_FETCH_ERR_EN
            r_mem_err[r_wr_ptr]  <= bus.instr_err_i;
`endif
        end
    end

    assign bus.instr_req_o   = (r_state == REQ);
    assign bus.instr_addr_o  = r_req_addr;
    assign bus.fetch_valid_o = w_fetch_valid;
    assign bus.fetch_rdata_o = w_fetch_valid ? r_mem_data[r_rd_ptr] : 32'h0000_0000;
    assign bus.fetch_addr_o  = w_fetch_valid ? r_mem_addr[r_rd_ptr] : 32'h0000_0000;
`ifdef CV32E40P_FETCH_ERR_EN
    assign bus.fetch_err_o   = w_fetch_valid && r_mem_err[r_rd_ptr];
`else
    assign bus.fetch_err_o   = 1'b0;
`endif
    assign busy_o      = (r_state == REQ) || (r_outstanding != {OUT_W{1'b0}}) ||
                         (r_discard != {OUT_W{1'b0}});
    assign occupancy_o = r_count;

`ifdef CV32E40P_ASSERT_ON
    cv32e40p_fetch_queue_chk #(.OUT_W(OUT_W)) u_chk (
        .clk         (clk),
        .rst_n       (rst_n),
        .rvalid      (bus.instr_rvalid_i),
        .outstanding (r_outstanding)
    );
`endif
endmodule

// File: tb/tb_cv32e40p_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_cv32e40p_fetch_queue
// Directed bench for cv32e40p_fetch_queue (DEPTH=4, MAX_OUTSTANDING=2).
// A small OBI responder queues granted addresses and returns them one per
// cycle while resp_en is set; read data is the address XOR a key.
// ----------------------------------------------------------------------------
module tb_cv32e40p_fetch_queue;
    localparam logic [31:0] KEY = 32'h5A5A_0000;

    logic        clk;
    logic        rst_n;
    logic        req_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        busy_o;
    logic [2:0]  occupancy_o;

    int          total;
    int          bad;
    logic        resp_en;
    logic [31:0] err_addr;
    logic [31:0] q[$];
    logic [31:0] gnt_log[$];

    cv32e40p_fetch_queue_if intf ();

    cv32e40p_fetch_queue #(.DEPTH(4), .MAX_OUTSTANDING(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_i         (req_i),
        .branch_i      (branch_i),
        .branch_addr_i (branch_addr_i),
        .bus           (intf),
        .busy_o        (busy_o),
        .occupancy_o   (occupancy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: note grant at the edge, then present the next response
    task automatic tick();
        logic        g;
        logic [31:0] a;
        g = intf.instr_req_o && intf.instr_gnt_i;
        a = intf.instr_addr_o;
        @(posedge clk);
        #1;
        if (g) begin
            q.push_back(a);
            gnt_log.push_back(a);
        end
        if (resp_en && (q.size() > 0)) begin
            a = q.pop_front();
            intf.instr_rvalid_i = 1'b1;
            intf.instr_rdata_i  = a ^ KEY;
            intf.instr_err_i    = (a == err_addr);
        end else begin
            intf.instr_rvalid_i = 1'b0;
            intf.instr_rdata_i  = 32'h0000_0000;
            intf.instr_err_i    = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   {31'd0, intf.instr_req_o},   32'd0);
        check({tag, "_addr"},  intf.instr_addr_o,           32'd0);
        check({tag, "_valid"}, {31'd0, intf.fetch_valid_o}, 32'd0);
        check({tag, "_rdata"}, intf.fetch_rdata_o,          32'd0);
        check({tag, "_faddr"}, intf.fetch_addr_o,           32'd0);
        check({tag, "_err"},   {31'd0, intf.fetch_err_o},   32'd0);
        check({tag, "_busy"},  {31'd0, busy_o},             32'd0);
        check({tag, "_occ"},   {29'd0, occupancy_o},        32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        resp_en = 1'b1;
        err_addr = 32'hFFFF_FFFF;
        rst_n = 1'b0;
        req_i = 1'b1;
        branch_i = 1'b0;
        branch_addr_i = 32'h0000_0000;
        intf.instr_gnt_i    = 1'b1;
        intf.instr_rvalid_i = 1'b0;
        intf.instr_rdata_i  = 32'h0000_0000;
        intf.instr_err_i    = 1'b0;
        intf.fetch_ready_i  = 1'b0;

        // Reset state, then no request until the first branch
        tick(); tick();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("unarmed_req", {31'd0, intf.instr_req_o}, 32'd0);

        // Branch to 0x80 (low bits ignored), fill FIFO back-to-back
        branch_i = 1'b1; branch_addr_i = 32'h0000_0083;
        tick();
        branch_i = 1'b0;
        check("arm_req_idle", {31'd0, intf.instr_req_o}, 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("b2b_req",  {31'd0, intf.instr_req_o}, 32'd1);
            check("b2b_addr", intf.instr_addr_o, 32'h0000_0080 + 32'(4 * i));
            tick();
        end
        tick();
        check("fill_ngnt", gnt_log.size(), 32'd4);
        check("fill_g3",   gnt_log[3], 32'h0000_008C);
        check("full_occ",  {29'd0, occupancy_o}, 32'd4);
        check("full_head", intf.fetch_addr_o, 32'h0000_0080);
        check("full_data", intf.fetch_rdata_o, 32'h0000_0080 ^ KEY);
        tick(); tick(); tick();
        check("full_noreq", {31'd0, intf.instr_req_o}, 32'd0);
        check("full_idle_busy", {31'd0, busy_o}, 32'd0);
        intf.fetch_ready_i = 1'b1;
        tick();
        intf.fetch_ready_i = 1'b0;
        check("pop_req",  {31'd0, intf.instr_req_o}, 32'd1);
        check("pop_addr", intf.instr_addr_o, 32'h0000_0090);
        check("pop_head", intf.fetch_addr_o, 32'h0000_0084);

        // Build two outstanding, then branch to 0x200
        resp_en = 1'b0;
        branch_i = 1'b1; branch_addr_i = 32'h0000_1000;
        tick();
        branch_i = 1'b0;
        check("flush_occ", {29'd0, occupancy_o}, 32'd0);
        tick(); tick();
        branch_i = 1'b1; branch_addr_i = 32'h0000_0200;
        tick();
        branch_i = 1'b0;
        resp_en = 1'b1;
        check("br2_occ",  {29'd0, occupancy_o}, 32'd0);
        check("br2_busy", {31'd0, busy_o}, 32'd1);
        tick(); tick(); tick();
        check("drop_occ", {29'd0, occupancy_o}, 32'd0);
        tick();
        check("br2_valid", {31'd0, intf.fetch_valid_o}, 32'd1);
        check("br2_head",  intf.fetch_addr_o, 32'h0000_0200);
        check("br2_data",  intf.fetch_rdata_o, 32'h0000_0200 ^ KEY);
        check("br2_occ1",  {29'd0, occupancy_o}, 32'd1);

        // Branch to 0x40, then branch to 0x300 while 0x40 waits for grant
        intf.fetch_ready_i = 1'b1;
        branch_i = 1'b1; branch_addr_i = 32'h0000_0040;
        tick();
        branch_i = 1'b0;
        intf.instr_gnt_i = 1'b0;
        tick();
        check("st_req",  {31'd0, intf.instr_req_o}, 32'd1);
        check("st_addr", intf.instr_addr_o, 32'h0000_0040);
        gnt_log.delete();
        branch_i = 1'b1; branch_addr_i = 32'h0000_0300;
        tick();
        branch_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("st_hold", intf.instr_addr_o, 32'h0000_0040);
            if (i < 2) tick();
        end
        intf.instr_gnt_i = 1'b1;
        tick();
        check("st_gnt_req",  {31'd0, intf.instr_req_o}, 32'd0);
        check("st_gnt_busy", {31'd0, busy_o}, 32'd1);
        tick();
        check("st_tgt_req",  {31'd0, intf.instr_req_o}, 32'd1);
        check("st_tgt_addr", intf.instr_addr_o, 32'h0000_0300);
        check("st_tgt_occ",  {29'd0, occupancy_o}, 32'd0);
        tick(); tick();
        check("st_log0", gnt_log[0], 32'h0000_0040);
        check("st_log1", gnt_log[1], 32'h0000_0300);
        check("st_head", intf.fetch_addr_o, 32'h0000_0300);

        // Streaming with ready held high: one entry, order preserved, pointers wrap
        for (int i = 0; i < 20; i++) begin
            check("str_occ",  {29'd0, occupancy_o}, 32'd1);
            check("str_addr", intf.fetch_addr_o, 32'h0000_0300 + 32'(4 * i));
            check("str_data", intf.fetch_rdata_o, (32'h0000_0300 + 32'(4 * i)) ^ KEY);
            tick();
        end

        // Reset with two transactions in flight
        resp_en = 1'b0;
        tick(); tick();
        check("pre_rst_busy", {31'd0, busy_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        q.delete();
        gnt_log.delete();
        resp_en = 1'b1;
        intf.fetch_ready_i = 1'b0;
        intf.instr_rvalid_i = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_noreq", {31'd0, intf.instr_req_o}, 32'd0);
        end

        // Bus error on the response for 0x504
        err_addr = 32'h0000_0504;
        branch_i = 1'b1; branch_addr_i = 32'h0000_0500;
        tick();
        branch_i = 1'b0;
        tick(); tick(); tick(); tick();
`ifdef CV32E40P_FETCH_ERR_EN
        check("err_halt_req", {31'd0, intf.instr_req_o}, 32'd0);
`else
        check("err_cont_req", {31'd0, intf.instr_req_o}, 32'd1);
`endif
        tick();
        intf.fetch_ready_i = 1'b1;
        tick();
        intf.fetch_ready_i = 1'b0;
        check("err_head", intf.fetch_addr_o, 32'h0000_0504);
`ifdef CV32E40P_FETCH_ERR_EN
        check("err_flag",  {31'd0, intf.fetch_err_o}, 32'd1);
        check("err_noreq", {31'd0, intf.instr_req_o}, 32'd0);
`else
        check("err_flag",  {31'd0, intf.fetch_err_o}, 32'd0);
        check("err_req",   {31'd0, intf.instr_req_o}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
